stream_scoreboard: RTL and testbench
====================================

Name: stream_scoreboard

Overview:
- Multi-channel, synthesisable successor to the single-stream TID checker.
- Tracks outstanding transactions per channel in a fixed-depth table.
- Flags unknown completions, duplicate issues, table overflow and (optionally) stale transactions.
- Sits between the CCI-P request/response paths in the ASE hardware shim; reports through counters, sticky error bits and a first-error capture register instead of simulator-only associative arrays.

Parameters:
NUM_CH, 2, number of independent request/response channels
TID_WIDTH, 32, transaction ID width
META_WIDTH, CCIP_TX_HDR_WIDTH, width of header/metadata stored per entry
DEPTH, 64, outstanding-entry capacity per channel (power of 2, >=2)
TIMEOUT_CYCLES, 4096, age limit before an entry is stale (timeout feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
valid_in  in  NUM_CH  per-channel issue strobe
tid_in  in  NUM_CH*TID_WIDTH  issued TID, channel c at [c*TID_WIDTH +: TID_WIDTH]
meta_in  in  NUM_CH*META_WIDTH  issued header, same packing
untracked_in  in  NUM_CH  issue carries no response (e.g. WrFence); not stored
valid_out  in  NUM_CH  per-channel completion strobe
tid_out  in  NUM_CH*TID_WIDTH  completed TID
err_clear  in  1  clears sticky errors and first-error capture
outstanding  out  NUM_CH*$clog2(DEPTH+1)  live entry count per channel
err_sticky  out  NUM_CH*4  per channel {timeout, overflow, duplicate, missing}
err_pulse  out  1  registered, high one cycle after any new error
err_valid  out  1  first-error capture valid
err_ch  out  $clog2(NUM_CH) (min 1)  channel of first error
err_code  out  2  0 missing, 1 duplicate, 2 overflow, 3 timeout
err_tid  out  TID_WIDTH  TID of first error
err_meta  out  META_WIDTH  stored/issued meta of first error (0 for missing)

Behaviour:
- Reset: all entry valid bits 0, all outputs 0. Async assert, release sampled on clk.
- Per channel: DEPTH entries of {valid, tid, meta, age}. Channels fully independent.
- Lookup: all issue/completion matches use the pre-cycle table contents. Updates commit at the clock edge. Outputs are registered, one-cycle latency.
- Issue (valid_in & !untracked_in):
  - TID already valid in table -> duplicate error; entry not re-inserted.
  - Table full (pre-cycle count == DEPTH) -> overflow error; dropped. A same-cycle completion does not rescue it.
  - Otherwise -> write lowest-index free entry; age = 0.
- Untracked issue: ignored entirely.
- Completion (valid_out):
  - TID matches a valid entry -> clear it (lowest index if several).
  - No match -> missing error.
  - Same-cycle issue of the same TID on the same channel is NOT a match: missing error, and the issue is still inserted.
- outstanding = inserts - clears, clamped to 0..DEPTH. Issue+completion in one cycle with both succeeding -> count unchanged.
- Errors: set err_sticky bit; pulse err_pulse.
  - Capture fields load only when err_valid == 0.
  - Multiple same-cycle errors: priority lowest channel, then code order missing > duplicate > overflow > timeout.
- err_clear: clears err_sticky, err_valid and capture next cycle. An error in the same cycle as err_clear wins: bit set, captured.
- Table is not flushed by err_clear, only by rst.

Optional Feature:
STREAM_SCOREBOARD_TIMEOUT_EN:
- Defined:
  - Each valid entry's age increments per cycle, saturating at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES raises a timeout error once for that entry (per-entry reported flag).
  - The entry remains valid until completed.
  - Multiple entries timing out in one cycle: lowest index captured.
- Undefined: no age counters synthesised; timeout bit and code 3 are never produced (tie 0).

Test Plan:
1. Reset, ch0 issue TIDs 0x10,0x11,0x12, complete 0x11,0x10,0x12 -> outstanding[0] 1,2,3,2,1,0; no errors.
2. ch1 completion TID 0xDEAD with empty table -> next cycle err_pulse=1, err_sticky[ch1].missing=1, err_ch=1, err_code=0, err_tid=0xDEAD.
3. DEPTH=4: issue 0..3 on ch0, then issue 4 together with completion of 0 -> overflow, outstanding[0]=3; retry issue 4 -> outstanding 4, no new error.
4. Issue 0x5 twice on ch0 -> duplicate error, outstanding=1. Issue 0x7 with untracked_in=1 -> outstanding stays 1. Error on ch0 and ch1 same cycle -> err_ch=0.
5. With _EN, TIMEOUT_CYCLES=16: issue 0x9, wait 16 cycles -> timeout error, err_code=3, err_meta=issued meta, single pulse only. Complete 0x9 -> outstanding 0. Without macro, no error after 1000 cycles.
6. Assert rst mid-traffic with 3 outstanding -> all outputs 0 immediately. After release, completing an old TID -> missing error.

Source files
------------

// File: rtl/stream_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : stream_scoreboard
// Purpose  : Multi-channel outstanding-transaction scoreboard. Flags unknown
//            completions, duplicate issues, table overflow and, when the macro
//            STREAM_SCOREBOARD_TIMEOUT_EN is defined, stale entries.
// Revision : 1.0 - initial release
// ============================================================================
module stream_scoreboard #(
   parameter int NUM_CH         = 2,
   parameter int TID_WIDTH      = 32,
   parameter int META_WIDTH     = 74,   // default sized for the CCI-P Tx header
   parameter int DEPTH          = 64,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_CH-1:0]                      valid_in,
   input  logic [NUM_CH*TID_WIDTH-1:0]            tid_in,
   input  logic [NUM_CH*META_WIDTH-1:0]           meta_in,
   input  logic [NUM_CH-1:0]                      untracked_in,
   input  logic [NUM_CH-1:0]                      valid_out,
   input  logic [NUM_CH*TID_WIDTH-1:0]            tid_out,
   input  logic                                   err_clear,
   output logic [NUM_CH*$clog2(DEPTH+1)-1:0]      outstanding,
   output logic [NUM_CH*4-1:0]                    err_sticky,
   output logic                                   err_pulse,
   output logic                                   err_valid,
   output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] err_ch,
   output logic [1:0]                             err_code,
   output logic [TID_WIDTH-1:0]                   err_tid,
   output logic [META_WIDTH-1:0]                  err_meta
);

   localparam int c_cnt_w = $clog2(DEPTH+1);
   localparam int c_idx_w = $clog2(DEPTH);
   localparam int c_chw   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("stream_scoreboard: DEPTH must be a power of 2 and >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("stream_scoreboard: TIMEOUT_CYCLES must be >= 1");
   end

   // Per-channel error report: bits {timeout, overflow, duplicate, missing}
   logic [3:0]            w_ch_err  [NUM_CH];
   logic [1:0]            w_ch_code [NUM_CH];
   logic [TID_WIDTH-1:0]  w_ch_tid  [NUM_CH];
   logic [META_WIDTH-1:0] w_ch_meta [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DEPTH-1:0]      vld_q, vld_d;
      logic [TID_WIDTH-1:0]  ent_tid_q  [DEPTH];
      logic [META_WIDTH-1:0] ent_meta_q [DEPTH];
      logic [c_cnt_w-1:0]    cnt_q, cnt_d;

      logic [TID_WIDTH-1:0]  w_itid, w_ctid, w_to_tid;
      logic [META_WIDTH-1:0] w_imeta, w_to_meta;
      logic                  w_issue, w_hit_issue, w_hit_cmpl, w_full;
      logic                  w_insert, w_clear, w_miss, w_dupe, w_ovf, w_to;
      logic [c_idx_w-1:0]    w_free_idx, w_clr_idx;
      logic [1:0]            w_code;
      logic [TID_WIDTH-1:0]  w_etid;
      logic [META_WIDTH-1:0] w_emeta;

      assign w_itid  = tid_in[c*TID_WIDTH +: TID_WIDTH];
      assign w_ctid  = tid_out[c*TID_WIDTH +: TID_WIDTH];
      assign w_imeta = meta_in[c*META_WIDTH +: META_WIDTH];

      // Descending scan so the lowest matching/free index wins.
      always_comb begin
         w_hit_issue = 1'b0;
         w_hit_cmpl  = 1'b0;
         w_free_idx  = '0;
         w_clr_idx   = '0;
         for (int e = DEPTH - 1; e >= 0; e--) begin
            if (vld_q[e] && (ent_tid_q[e] == w_itid)) begin
               w_hit_issue = 1'b1;
            end
            if (vld_q[e] && (ent_tid_q[e] == w_ctid)) begin
               w_hit_cmpl = 1'b1;
               w_clr_idx  = e[c_idx_w-1:0];
            end
            if (!vld_q[e]) begin
               w_free_idx = e[c_idx_w-1:0];
            end
         end
      end

      assign w_issue  = valid_in[c] & ~untracked_in[c];
      assign w_full   = (cnt_q == c_cnt_w'(DEPTH));
      assign w_dupe   = w_issue & w_hit_issue;
      assign w_ovf    = w_issue & ~w_hit_issue & w_full;
      assign w_insert = w_issue & ~w_hit_issue & ~w_full;
      assign w_clear  = valid_out[c] & w_hit_cmpl;
      assign w_miss   = valid_out[c] & ~w_hit_cmpl;

      always_comb begin
         vld_d = vld_q;
         if (w_insert) vld_d[w_free_idx] = 1'b1;
         if (w_clear)  vld_d[w_clr_idx]  = 1'b0;
      end

      // An insert and a clear never collide: one targets a free slot, the other a live one.
      assign cnt_d = cnt_q + c_cnt_w'(w_insert) - c_cnt_w'(w_clear);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= '0;
            cnt_q <= '0;
         end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
         end
      end

      always_ff @(posedge clk) begin
         if (w_insert) begin
            ent_tid_q[w_free_idx]  <= w_itid;
            ent_meta_q[w_free_idx] <= w_imeta;
         end
      end

`ifdef STREAM_SCOREBOARD_TIMEOUT_EN
      localparam int c_age_w = $clog2(TIMEOUT_CYCLES + 1);
      logic [c_age_w-1:0] age_q [DEPTH];
      logic [DEPTH-1:0]   rep_q;
      logic [c_idx_w-1:0] w_to_idx;

      always_comb begin
         w_to     = 1'b0;
         w_to_idx = '0;
         for (int e = DEPTH - 1; e >= 0; e--) begin
            if (vld_q[e] && !rep_q[e] && (age_q[e] == c_age_w'(TIMEOUT_CYCLES))) begin
               w_to     = 1'b1;
               w_to_idx = e[c_idx_w-1:0];
            end
         end
      end

      assign w_to_tid  = ent_tid_q[w_to_idx];
      assign w_to_meta = ent_meta_q[w_to_idx];

      // Only the reported entry is marked; other stale entries report on later cycles.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rep_q <= '0;
            for (int e = 0; e < DEPTH; e++) age_q[e] <= '0;
         end else begin
            for (int e = 0; e < DEPTH; e++) begin
               if (w_insert && (w_free_idx == c_idx_w'(e))) begin
                  age_q[e] <= '0;
                  rep_q[e] <= 1'b0;
               end else if (vld_q[e]) begin
                  if (age_q[e] != c_age_w'(TIMEOUT_CYCLES)) age_q[e] <= age_q[e] + 1'b1;
                  if (w_to && (w_to_idx == c_idx_w'(e))) rep_q[e] <= 1'b1;
               end
            end
         end
      end
`else
      assign w_to      = 1'b0;
      assign w_to_tid  = '0;
      assign w_to_meta = '0;
`endif

      always_comb begin
         w_code  = 2'd3;
         w_etid  = w_to_tid;
         w_emeta = w_to_meta;
         if (w_miss) begin
            w_code  = 2'd0;
            w_etid  = w_ctid;
            w_emeta = '0;
         end else if (w_dupe || w_ovf) begin
            w_code  = w_dupe ? 2'd1 : 2'd2;
            w_etid  = w_itid;
            w_emeta = w_imeta;
         end
      end

      assign w_ch_err[c]  = {w_to, w_ovf, w_dupe, w_miss};
      assign w_ch_code[c] = w_code;
      assign w_ch_tid[c]  = w_etid;
      assign w_ch_meta[c] = w_emeta;
      assign outstanding[c*c_cnt_w +: c_cnt_w] = cnt_q;
   end

   logic [NUM_CH*4-1:0]   sticky_q, sticky_d;
   logic                  pulse_q;
   logic                  cap_vld_q, cap_vld_d;
   logic [c_chw-1:0]      cap_ch_q, cap_ch_d;
   logic [1:0]            cap_code_q, cap_code_d;
   logic [TID_WIDTH-1:0]  cap_tid_q, cap_tid_d;
   logic [META_WIDTH-1:0] cap_meta_q, cap_meta_d;
   logic                  w_any;
   logic [c_chw-1:0]      w_sel_ch;
   logic [1:0]            w_sel_code;
   logic [TID_WIDTH-1:0]  w_sel_tid;
   logic [META_WIDTH-1:0] w_sel_meta;

   always_comb begin
      w_any      = 1'b0;
      w_sel_ch   = '0;
      w_sel_code = '0;
      w_sel_tid  = '0;
      w_sel_meta = '0;
      sticky_d   = err_clear ? '0 : sticky_q;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         sticky_d[c*4 +: 4] = sticky_d[c*4 +: 4] | w_ch_err[c];
         if (|w_ch_err[c]) begin
            w_any      = 1'b1;
            w_sel_ch   = c[c_chw-1:0];
            w_sel_code = w_ch_code[c];
            w_sel_tid  = w_ch_tid[c];
            w_sel_meta = w_ch_meta[c];
         end
      end
   end

   // A new error in the clearing cycle takes the freshly emptied capture slot.
   always_comb begin
      cap_vld_d  = cap_vld_q;
      cap_ch_d   = cap_ch_q;
      cap_code_d = cap_code_q;
      cap_tid_d  = cap_tid_q;
      cap_meta_d = cap_meta_q;
      if (err_clear) begin
         cap_vld_d  = 1'b0;
         cap_ch_d   = '0;
         cap_code_d = '0;
         cap_tid_d  = '0;
         cap_meta_d = '0;
      end
      if (w_any && (!cap_vld_q || err_clear)) begin
         cap_vld_d  = 1'b1;
         cap_ch_d   = w_sel_ch;
         cap_code_d = w_sel_code;
         cap_tid_d  = w_sel_tid;
         cap_meta_d = w_sel_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q   <= '0;
         pulse_q    <= 1'b0;
         cap_vld_q  <= 1'b0;
         cap_ch_q   <= '0;
         cap_code_q <= '0;
         cap_tid_q  <= '0;
         cap_meta_q <= '0;
      end else begin
         sticky_q   <= sticky_d;
         pulse_q    <= w_any;
         cap_vld_q  <= cap_vld_d;
         cap_ch_q   <= cap_ch_d;
         cap_code_q <= cap_code_d;
         cap_tid_q  <= cap_tid_d;
         cap_meta_q <= cap_meta_d;
      end
   end

   assign err_sticky = sticky_q;
   assign err_pulse  = pulse_q;
   assign err_valid  = cap_vld_q;
   assign err_ch     = cap_ch_q;
   assign err_code   = cap_code_q;
   assign err_tid    = cap_tid_q;
   assign err_meta   = cap_meta_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_scoreboard
// Purpose  : Scoreboard bench for stream_scoreboard (NUM_CH=2, DEPTH=4).
//            Timeout scenario follows STREAM_SCOREBOARD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_scoreboard;

   localparam int NCH = 2;
   localparam int TW  = 32;
   localparam int MW  = 16;
   localparam int DP  = 4;
   localparam int CW  = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NCH-1:0]    valid_in, untracked_in, valid_out;
   logic [NCH*TW-1:0] tid_in, tid_out;
   logic [NCH*MW-1:0] meta_in;
   logic              err_clear;
   logic [NCH*CW-1:0] outstanding;
   logic [NCH*4-1:0]  err_sticky;
   logic              err_pulse, err_valid;
   logic [0:0]        err_ch;
   logic [1:0]        err_code;
   logic [TW-1:0]     err_tid;
   logic [MW-1:0]     err_meta;

   stream_scoreboard #(
      .NUM_CH(NCH), .TID_WIDTH(TW), .META_WIDTH(MW), .DEPTH(DP), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst),
      .valid_in(valid_in), .tid_in(tid_in), .meta_in(meta_in),
      .untracked_in(untracked_in), .valid_out(valid_out), .tid_out(tid_out),
      .err_clear(err_clear), .outstanding(outstanding), .err_sticky(err_sticky),
      .err_pulse(err_pulse), .err_valid(err_valid), .err_ch(err_ch),
      .err_code(err_code), .err_tid(err_tid), .err_meta(err_meta)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            ch;
      int            code;
      logic [TW-1:0] tid;
      logic [MW-1:0] meta;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [CW-1:0] outs(input int ch);
      return outstanding[ch*CW +: CW];
   endfunction

   task automatic idle();
      valid_in = '0; untracked_in = '0; valid_out = '0; err_clear = 1'b0;
      tid_in = '0; tid_out = '0; meta_in = '0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic issue(input int ch, input logic [TW-1:0] t, input logic [MW-1:0] m,
                        input bit untr = 1'b0);
      valid_in[ch]         = 1'b1;
      untracked_in[ch]     = untr;
      tid_in[ch*TW +: TW]  = t;
      meta_in[ch*MW +: MW] = m;
   endtask

   task automatic compl(input int ch, input logic [TW-1:0] t);
      valid_out[ch]        = 1'b1;
      tid_out[ch*TW +: TW] = t;
   endtask

   task automatic expect_err(input int ch, input int code, input logic [TW-1:0] t,
                             input logic [MW-1:0] m);
      exp_t e;
      e.ch = ch; e.code = code; e.tid = t; e.meta = m;
      exp_q.push_back(e);
   endtask

   task automatic step();
      tick();
      idle();
   endtask

   task automatic clear_errs();
      err_clear = 1'b1;
      step();
   endtask

   // Monitor: every error pulse must line up with the next expected capture.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && err_pulse) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_err_pulse", 64'(err_pulse), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("err_valid", 64'(err_valid), 64'd1);
               chk("err_ch",    64'(err_ch),    64'(e.ch));
               chk("err_code",  64'(err_code),  64'(e.code));
               chk("err_tid",   64'(err_tid),   64'(e.tid));
               chk("err_meta",  64'(err_meta),  64'(e.meta));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      idle();
      #1 rst = 1'b1;
      tick(); tick();
      chk("reset_outstanding", 64'(outstanding), 64'd0);
      chk("reset_sticky",      64'(err_sticky),  64'd0);
      chk("reset_valid",       64'(err_valid),   64'd0);
      chk("reset_pulse",       64'(err_pulse),   64'd0);
      rst = 1'b0;
      tick();

      // Basic issue/complete bookkeeping on ch0
      issue(0, 32'h10, 16'hA10); step(); chk("t1_out_a", 64'(outs(0)), 64'd1);
      issue(0, 32'h11, 16'hA11); step(); chk("t1_out_b", 64'(outs(0)), 64'd2);
      issue(0, 32'h12, 16'hA12); step(); chk("t1_out_c", 64'(outs(0)), 64'd3);
      compl(0, 32'h11);          step(); chk("t1_out_d", 64'(outs(0)), 64'd2);
      compl(0, 32'h10);          step(); chk("t1_out_e", 64'(outs(0)), 64'd1);
      compl(0, 32'h12);          step(); chk("t1_out_f", 64'(outs(0)), 64'd0);
      chk("t1_no_err", 64'(err_sticky), 64'd0);

      // Missing completion on ch1
      compl(1, 32'hDEAD); expect_err(1, 0, 32'hDEAD, 16'h0); step();
      chk("t2_sticky", 64'(err_sticky), 64'h10);
      clear_errs();
      chk("t2_cleared_sticky", 64'(err_sticky), 64'd0);
      chk("t2_cleared_valid",  64'(err_valid),  64'd0);

      // Overflow at DEPTH=4; a same-cycle completion does not make room
      for (int i = 0; i < 4; i++) begin
         issue(0, 32'(i), 16'(16'h30 + i)); step();
      end
      chk("t3_full", 64'(outs(0)), 64'd4);
      issue(0, 32'h4, 16'h34); compl(0, 32'h0); expect_err(0, 2, 32'h4, 16'h34); step();
      chk("t3_after_ovf", 64'(outs(0)), 64'd3);
      chk("t3_sticky", 64'(err_sticky), 64'h04);
      clear_errs();
      issue(0, 32'h4, 16'h34); step();
      chk("t3_retry", 64'(outs(0)), 64'd4);
      chk("t3_retry_no_err", 64'(err_sticky), 64'd0);
      for (int i = 1; i <= 4; i++) begin
         compl(0, 32'(i)); step();
      end
      chk("t3_drained", 64'(outs(0)), 64'd0);

      // Duplicate, capture hold, untracked issue
      issue(0, 32'h5, 16'h55); step();
      issue(0, 32'h5, 16'h56); expect_err(0, 1, 32'h5, 16'h56); step();
      chk("t4_dup_out", 64'(outs(0)), 64'd1);
      compl(1, 32'h55); expect_err(0, 1, 32'h5, 16'h56); step();
      chk("t4_sticky_both", 64'(err_sticky), 64'h12);
      clear_errs();
      issue(0, 32'h5, 16'h57, 1'b1); step();
      issue(0, 32'h7, 16'h77, 1'b1); step();
      chk("t4_untracked_out", 64'(outs(0)), 64'd1);
      chk("t4_untracked_no_err", 64'(err_sticky), 64'd0);
      compl(0, 32'h5); step();
      chk("t4_out_zero", 64'(outs(0)), 64'd0);
      compl(0, 32'h77); compl(1, 32'h88); expect_err(0, 0, 32'h77, 16'h0); step();
      chk("t4_dual_sticky", 64'(err_sticky), 64'h11);
      err_clear = 1'b1; compl(1, 32'h99); expect_err(1, 0, 32'h99, 16'h0); step();
      chk("t4_clear_vs_err_sticky", 64'(err_sticky), 64'h10);
      clear_errs();

      // Same-cycle issue and completion of one TID: miss, but still inserted
      issue(0, 32'h20, 16'h20); compl(0, 32'h20); expect_err(0, 0, 32'h20, 16'h0); step();
      chk("t4_same_tid_out", 64'(outs(0)), 64'd1);
      clear_errs();
      compl(0, 32'h20); step();
      chk("t4_same_tid_done", 64'(outs(0)), 64'd0);
      issue(0, 32'h30, 16'h1); step();
      issue(0, 32'h31, 16'h2); compl(0, 32'h30); step();
      chk("t4_swap_out", 64'(outs(0)), 64'd1);
      compl(0, 32'h31); step();
      chk("t4_swap_done", 64'(outs(0)), 64'd0);

`ifdef STREAM_SCOREBOARD_TIMEOUT_EN
      issue(0, 32'h9, 16'h99); expect_err(0, 3, 32'h9, 16'h99); step();
      lat = 0;
      while (!err_valid && lat < 40) begin
         tick(); lat++;
      end
      chk("t5_timeout_seen", 64'(err_valid), 64'd1);
      chk("t5_timeout_sticky", 64'(err_sticky), 64'h08);
      for (int i = 0; i < 30; i++) tick();
      clear_errs();
      compl(0, 32'h9); step();
      chk("t5_out_zero", 64'(outs(0)), 64'd0);
`else
      issue(0, 32'h9, 16'h99); step();
      lat = 0;
      for (int i = 0; i < 1000; i++) begin
         tick(); lat++;
      end
      chk("t5_no_timeout_sticky", 64'(err_sticky), 64'd0);
      chk("t5_no_timeout_valid",  64'(err_valid),  64'd0);
      compl(0, 32'h9); step();
      chk("t5_out_zero", 64'(outs(0)), 64'd0);
`endif

      // Async reset mid-traffic
      issue(0, 32'h40, 16'h1); issue(1, 32'h42, 16'h3); step();
      issue(0, 32'h41, 16'h2); compl(1, 32'hBAD); expect_err(1, 0, 32'hBAD, 16'h0); step();
      chk("t6_pre_out", 64'(outstanding), 64'h0A);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_out",    64'(outstanding), 64'd0);
      chk("t6_rst_sticky", 64'(err_sticky),  64'd0);
      chk("t6_rst_valid",  64'(err_valid),   64'd0);
      chk("t6_rst_pulse",  64'(err_pulse),   64'd0);
      chk("t6_rst_tid",    64'(err_tid),     64'd0);
      tick(); tick();
      rst = 1'b0;
      tick();
      compl(0, 32'h40); expect_err(0, 0, 32'h40, 16'h0); step();
      chk("t6_old_tid_missing", 64'(err_sticky), 64'h01);
      clear_errs();
      tick(); tick(); tick();
      chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
